// File: rtl/fifo_ptr_ctrl.sv
// Single-clock FIFO pointer/status controller: wrap-bit pointers, registered flags and level.
// Optional sticky overflow/underflow flags are built only when FIFO_PTR_ERR_EN is defined.
module fifo_ptr_ctrl #(
    parameter int ADDR      = 5,
    parameter int AF_THRESH = 2**ADDR - 2,
    parameter int AE_THRESH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic            rd_en,
    input  logic            err_clr,
    output logic [ADDR-1:0] waddr,
    output logic [ADDR-1:0] raddr,
    output logic            mem_we,
    output logic            rd_ack,
    output logic [ADDR:0]   wptr,
    output logic [ADDR:0]   rptr,
    output logic [ADDR:0]   level,
    output logic            full,
    output logic            empty,
    output logic            almost_full,
    output logic            almost_empty,
    output logic            overflow,
    output logic            underflow
);

    localparam logic [ADDR:0] L_AF = (ADDR+1)'(AF_THRESH);
    localparam logic [ADDR:0] L_AE = (ADDR+1)'(AE_THRESH);

    logic [ADDR:0] r_wptr;
    logic [ADDR:0] r_rptr;
    logic [ADDR:0] r_level;
    logic          r_full;
    logic          r_empty;
    logic          r_almost_full;
    logic          r_almost_empty;

    logic          w_push;
    logic          w_pop;
    logic [ADDR:0] w_wptr_next;
    logic [ADDR:0] w_rptr_next;
    logic [ADDR:0] w_level_next;

    assign w_push       = wr_en & ~r_full;
    assign w_pop        = rd_en & ~r_empty;
    assign w_wptr_next  = r_wptr + {{ADDR{1'b0}}, w_push};
    assign w_rptr_next  = r_rptr + {{ADDR{1'b0}}, w_pop};
    assign w_level_next = w_wptr_next - w_rptr_next;

    // NOTE: flags are derived from the next-state pointers so they land in the
    // same cycle as the pointers they describe; deriving them from r_wptr/r_rptr
    // would leave a one-cycle stale window and allow a push into a full FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_level        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= (L_AF == '0);
            r_almost_empty <= 1'b1;
        end else begin
            r_wptr         <= w_wptr_next;
            r_rptr         <= w_rptr_next;
            r_level        <= w_level_next;
            r_full         <= (w_wptr_next[ADDR] != w_rptr_next[ADDR]) &&
                              (w_wptr_next[ADDR-1:0] == w_rptr_next[ADDR-1:0]);
            r_empty        <= (w_wptr_next == w_rptr_next);
            r_almost_full  <= (w_level_next >= L_AF);
            r_almost_empty <= (w_level_next <= L_AE);
        end
    end

`ifdef FIFO_PTR_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow  & ~err_clr) | (wr_en & r_full);
            r_underflow <= (r_underflow & ~err_clr) | (rd_en & r_empty);
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = err_clr;
    assign overflow         = 1'b0;
    assign underflow        = 1'b0;
`endif

    assign waddr        = r_wptr[ADDR-1:0];
    assign raddr        = r_rptr[ADDR-1:0];
    assign mem_we       = w_push;
    assign rd_ack       = w_pop;
    assign wptr         = r_wptr;
    assign rptr         = r_rptr;
    assign level        = r_level;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Self-checking bench for fifo_ptr_ctrl: directed scenarios plus randomized traffic
// against an occupancy/transfer-count model. Honours FIFO_PTR_ERR_EN like the RTL.
module tb_fifo_ptr_ctrl;

    localparam int ADDR  = 5;
    localparam int DEPTH = 2**ADDR;
    localparam int PMOD  = 2**(ADDR+1);
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en;
    logic            rd_en;
    logic            err_clr;
    logic [ADDR-1:0] waddr;
    logic [ADDR-1:0] raddr;
    logic            mem_we;
    logic            rd_ack;
    logic [ADDR:0]   wptr;
    logic [ADDR:0]   rptr;
    logic [ADDR:0]   level;
    logic            full;
    logic            empty;
    logic            almost_full;
    logic            almost_empty;
    logic            overflow;
    logic            underflow;

    int checks = 0;
    int errors = 0;

    // Model: occupancy plus total accepted pushes/pops since reset.
    int m_count = 0;
    int m_wtot  = 0;
    int m_rtot  = 0;
    bit m_ovf   = 0;
    bit m_unf   = 0;

    always #5 clk = ~clk;

    fifo_ptr_ctrl #(.ADDR(ADDR), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .err_clr      (err_clr),
        .waddr        (waddr),
        .raddr        (raddr),
        .mem_we       (mem_we),
        .rd_ack       (rd_ack),
        .wptr         (wptr),
        .rptr         (rptr),
        .level        (level),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check accept strobes mid-cycle, check state after posedge.
    task automatic step(input bit w, input bit r, input bit c, input bit rs);
        bit push;
        bit pop;
        @(negedge clk);
        wr_en   = w;
        rd_en   = r;
        err_clr = c;
        rst     = rs;
        push = w && (m_count < DEPTH);
        pop  = r && (m_count > 0);
        #1;
        check("mem_we", {31'd0, mem_we}, {31'd0, push});
        check("rd_ack", {31'd0, rd_ack}, {31'd0, pop});
        @(posedge clk);
        if (rs) begin
            m_count = 0; m_wtot = 0; m_rtot = 0; m_ovf = 0; m_unf = 0;
        end else begin
`ifdef FIFO_PTR_ERR_EN
            if (c) begin m_ovf = 0; m_unf = 0; end
            if (w && m_count == DEPTH) m_ovf = 1;
            if (r && m_count == 0) m_unf = 1;
`endif
            m_count = m_count + int'(push) - int'(pop);
            m_wtot  = m_wtot + int'(push);
            m_rtot  = m_rtot + int'(pop);
        end
        #1;
        check("wptr",  32'(wptr),  32'(m_wtot % PMOD));
        check("rptr",  32'(rptr),  32'(m_rtot % PMOD));
        check("waddr", 32'(waddr), 32'(m_wtot % DEPTH));
        check("raddr", 32'(raddr), 32'(m_rtot % DEPTH));
        check("level", 32'(level), 32'(m_count));
        check("full",  {31'd0, full},  {31'd0, m_count == DEPTH});
        check("empty", {31'd0, empty}, {31'd0, m_count == 0});
        check("almost_full",  {31'd0, almost_full},  {31'd0, m_count >= AF});
        check("almost_empty", {31'd0, almost_empty}, {31'd0, m_count <= AE});
        check("overflow",  {31'd0, overflow},  {31'd0, m_ovf});
        check("underflow", {31'd0, underflow}, {31'd0, m_unf});
        check("inv_full_and_empty", {31'd0, full & empty}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        repeat (2) @(posedge clk);

        // Reset with traffic requested, then idle.
        step(1, 1, 0, 1);
        step(0, 0, 0, 0);

        // Fill from empty to full.
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0);
        check("tp2_wptr_full", 32'(wptr), 32'h20);
        check("tp2_rptr_full", 32'(rptr), 32'h0);

        // Push+pop while full, then refill.
        step(1, 1, 0, 0);
        check("tp3_level", 32'(level), 32'd31);
        step(1, 0, 0, 0);

        // Drain, then push+pop while empty.
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        check("tp4_level", 32'(level), 32'd1);
        step(0, 1, 0, 0);

        // Error flags: overflow, clear, underflow with simultaneous clear.
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);

        // Pre-fill 16, then alternating 3 pops / 3 pushes.
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            step((i % 6) >= 3, (i % 6) < 3, 0, 0);
            check("tp5_level_range", {31'd0, (level >= 13) && (level <= 16)}, 32'd1);
        end

        // Randomized traffic with fill-biased and drain-biased phases.
        for (int ph = 0; ph < 20; ph++) begin
            int bias = (ph % 2 == 0) ? 80 : 20;
            for (int i = 0; i < 100; i++) begin
                step($urandom_range(99) < bias,
                     $urandom_range(99) >= bias,
                     $urandom_range(99) < 10,
                     $urandom_range(999) < 3);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
